// File: rtl/fifo_blk_pkg.sv
// Shared definitions for the block-RAM FIFO controller: depth helper and
// the occupancy encoding of the two-entry output stage.
package fifo_blk_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } occ_t;

  function automatic int unsigned depth_of(input int unsigned aw);
    return 32'd1 << aw;
  endfunction

endpackage

// File: rtl/fifo_blk_ctrl.sv
// FIFO controller around an external dual-port RAM with a head/skid output stage.
// Optional level/almost_full reporting is built when FIFO_BLK_CTRL_LEVEL_EN is defined.
module fifo_blk_ctrl
  import fifo_blk_pkg::*;
#(
  parameter int DATAWIDTH = 8,
  parameter int ADDRWIDTH = 9,
  parameter int AF_LEVEL  = depth_of(ADDRWIDTH) - 4
) (
  input  logic                 clk,
  input  logic                 reset_l,
  input  logic [DATAWIDTH-1:0] in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [DATAWIDTH-1:0] out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DATAWIDTH-1:0] ram_wr_data,
  output logic [ADDRWIDTH-1:0] ram_wr_addr,
  output logic                 ram_we,
  output logic [ADDRWIDTH-1:0] ram_rd_addr,
  input  logic [DATAWIDTH-1:0] ram_rd_data
`ifdef FIFO_BLK_CTRL_LEVEL_EN
  ,
  output logic [ADDRWIDTH+1:0] level,
  output logic                 almost_full
`endif
);

  localparam int unsigned      DEPTH    = depth_of(ADDRWIDTH);
  localparam logic [ADDRWIDTH:0] FULL_CNT = (ADDRWIDTH+1)'(DEPTH);

  logic [ADDRWIDTH-1:0] wr_ptr;
  logic [ADDRWIDTH-1:0] rd_ptr;
  logic [ADDRWIDTH:0]   ram_cnt;
  logic [ADDRWIDTH:0]   ram_cnt_nxt;
  logic                 rd_pend;
  logic                 rd_en;
  logic                 push;
  logic                 pop;
  occ_t                 occ;
  occ_t                 occ_nxt;
  logic [DATAWIDTH-1:0] head_nxt;
  logic [DATAWIDTH-1:0] skid_p2;
  logic [DATAWIDTH-1:0] skid_nxt;

  function automatic logic [1:0] occ_count(input occ_t o);
    case (o)
      ONE:     return 2'd1;
      TWO:     return 2'd2;
      default: return 2'd0;
    endcase
  endfunction

  assign push        = in_valid & in_ready;
  assign pop         = out_valid & out_ready;
  assign ram_wr_data = in_data;
  assign ram_wr_addr = wr_ptr;
  assign ram_we      = push;
  assign ram_rd_addr = rd_ptr;

  // Stage 0: read issue; only fetch when the output stage has room for it.
  assign rd_en = (ram_cnt != '0) &&
                 (({1'b0, occ_count(occ)} + {2'b00, rd_pend}) < (3'd2 + {2'b00, pop}));

  assign ram_cnt_nxt = ram_cnt + {{ADDRWIDTH{1'b0}}, push} - {{ADDRWIDTH{1'b0}}, rd_en};

  // Stage 2: capture returning RAM data into head, or skid when head is held.
  always_comb begin
    occ_nxt  = occ;
    head_nxt = out_data;
    skid_nxt = skid_p2;
    case (occ)
      EMPTY: begin
        if (rd_pend) begin
          head_nxt = ram_rd_data;
          occ_nxt  = ONE;
        end
      end
      ONE: begin
        if (pop && rd_pend) begin
          head_nxt = ram_rd_data;
        end else if (pop) begin
          occ_nxt = EMPTY;
        end else if (rd_pend) begin
          skid_nxt = ram_rd_data;
          occ_nxt  = TWO;
        end
      end
      TWO: begin
        if (pop) begin
          head_nxt = skid_p2;
          if (rd_pend) skid_nxt = ram_rd_data;
          else         occ_nxt  = ONE;
        end
      end
      default: occ_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      ram_cnt   <= '0;
      rd_pend   <= 1'b0;
      occ       <= EMPTY;
      out_valid <= 1'b0;
      out_data  <= '0;
      in_ready  <= 1'b0;
    end else begin
      if (push)  wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      ram_cnt   <= ram_cnt_nxt;
      rd_pend   <= rd_en;
      occ       <= occ_nxt;
      out_valid <= (occ_nxt != EMPTY);
      out_data  <= head_nxt;
      in_ready  <= (ram_cnt_nxt != FULL_CNT);
    end
  end

  // Skid contents are qualified by occ, so they need no reset.
  always_ff @(posedge clk) begin
    skid_p2 <= skid_nxt;
  end

`ifdef FIFO_BLK_CTRL_LEVEL_EN
  localparam logic [ADDRWIDTH+1:0] AF_THR = (ADDRWIDTH+2)'(AF_LEVEL);

  logic [ADDRWIDTH+1:0] level_nxt;

  assign level_nxt = {1'b0, ram_cnt_nxt} + {{(ADDRWIDTH+1){1'b0}}, rd_en} +
                     {{ADDRWIDTH{1'b0}}, occ_count(occ_nxt)};

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      level       <= '0;
      almost_full <= 1'b0;
    end else begin
      level       <= level_nxt;
      almost_full <= (level_nxt >= AF_THR);
    end
  end
`endif

endmodule
